// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode map, FSM state encoding and opcode
// classification helpers for the sequential ALU (alu_seq) and its
// combinational arithmetic core (alu_seq_arith).
package alu_seq_pkg;

  localparam int OP_WIDTH = 4;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_SHR = 4'b0100,
    OP_ASR = 4'b0101,
    OP_ADC = 4'b0110,
    OP_SHL = 4'b1000
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

  // Opcodes handled by the 1-bit-per-cycle shift iterator.
  function automatic logic is_shift(input logic [OP_WIDTH-1:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
  endfunction

  // Opcodes whose carry_out is remembered for a later ADC.
  function automatic logic is_arith(input logic [OP_WIDTH-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC);
  endfunction

  function automatic logic is_legal(input logic [OP_WIDTH-1:0] op);
    return is_shift(op) || is_arith(op) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/alu_seq_arith.sv
// alu_seq_arith: combinational single-cycle part of the ALU.
//   a, b     : operands
//   op       : opcode (alu_seq_pkg::op_e values)
//   c_in     : stored carry, used by ADC only
//   result   : ADD/SUB/ADC/AND/OR result, 0 for any other opcode
//   carry    : carry out of the WIDTH+1 bit sum (SUB: 1 = no borrow)
//   overflow : signed overflow of the add/sub
module alu_seq_arith
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [OP_WIDTH-1:0] op,
  input  logic                c_in,
  output logic [WIDTH-1:0]    result,
  output logic                carry,
  output logic                overflow
);

  logic [WIDTH-1:0] addend;
  logic             cin;
  logic [WIDTH:0]   sum_ext;
  logic             add_ovf;

  // SUB is a + ~b + 1, so every arithmetic op shares one adder.
  assign addend  = (op == OP_SUB) ? ~b : b;
  assign cin     = (op == OP_SUB) ? 1'b1 : ((op == OP_ADC) ? c_in : 1'b0);
  assign sum_ext = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};

  // Overflow judged on the effective addend's sign (~b for SUB).
  assign add_ovf = (a[WIDTH-1] == addend[WIDTH-1]) &&
                   (sum_ext[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ADC: begin
        result   = sum_ext[WIDTH-1:0];
        carry    = sum_ext[WIDTH];
        overflow = add_ovf;
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshake on both sides.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : request handshake (in_ready high in IDLE)
//   a, b, menu           : operands and opcode, sampled on accept only;
//                          b[SHW-1:0] is the shift amount for shifts
//   out_valid / out_ready: result handshake (out_valid high in DONE)
//   Resultado            : registered result
//   carry_out, overflow  : registered carry/no-borrow/last bit out, overflow
//   cero, negativo       : registered zero / sign of Resultado
// ALU ops complete in one cycle; shifts by k take k extra cycles.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [OP_WIDTH-1:0] menu,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    Resultado,
  output logic                carry_out,
  output logic                overflow,
  output logic                cero,
  output logic                negativo
);

  state_e              state_reg;
  logic [WIDTH-1:0]    work_reg;
  logic [OP_WIDTH-1:0] op_reg;
  logic [SHW-1:0]      cnt_reg;
  logic                c_reg;
  logic [WIDTH-1:0]    res_reg;
  logic                carry_reg;
  logic                ovf_reg;
  logic                cero_reg;
  logic                neg_reg;

  logic [WIDTH-1:0]    alu_res;
  logic                alu_carry;
  logic                alu_ovf;

  logic [WIDTH-1:0]    shl_next;
  logic [WIDTH-1:0]    shr_next;
  logic [WIDTH-1:0]    step_next;
  logic                step_out;

  // Non-shift ops are evaluated straight from the accept-cycle inputs.
  alu_seq_arith #(
    .WIDTH(WIDTH)
  ) u_arith (
    .a       (a),
    .b       (b),
    .op      (menu),
    .c_in    (c_reg),
    .result  (alu_res),
    .carry   (alu_carry),
    .overflow(alu_ovf)
  );

  // One-position shift network applied to the working register.
  // The vacated MSB of a right shift is the sign bit for ASR, else 0.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (gi == 0) begin : g_lsb
      assign shl_next[gi] = 1'b0;
    end else begin : g_lsb_n
      assign shl_next[gi] = work_reg[gi-1];
    end
    if (gi == WIDTH - 1) begin : g_msb
      assign shr_next[gi] = (op_reg == OP_ASR) ? work_reg[WIDTH-1] : 1'b0;
    end else begin : g_msb_n
      assign shr_next[gi] = work_reg[gi+1];
    end
  end

  assign step_next = (op_reg == OP_SHL) ? shl_next : shr_next;
  assign step_out  = (op_reg == OP_SHL) ? work_reg[WIDTH-1] : work_reg[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      op_reg    <= '0;
      cnt_reg   <= '0;
      c_reg     <= 1'b0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      cero_reg  <= 1'b0;
      neg_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg   <= menu;
            work_reg <= a;
            cnt_reg  <= b[SHW-1:0];
            if (is_shift(menu)) begin
              if (b[SHW-1:0] == '0) begin
                // Shift by zero passes a through with nothing shifted out.
                res_reg   <= a;
                carry_reg <= 1'b0;
                ovf_reg   <= 1'b0;
                cero_reg  <= (a == '0);
                neg_reg   <= a[WIDTH-1];
                state_reg <= DONE;
              end else begin
                state_reg <= EXEC;
              end
            end else begin
              res_reg   <= alu_res;
              carry_reg <= alu_carry;
              ovf_reg   <= alu_ovf;
              // Illegal opcodes report every flag as 0, cero included.
              cero_reg  <= is_legal(menu) && (alu_res == '0);
              neg_reg   <= alu_res[WIDTH-1];
              state_reg <= DONE;
            end
          end
        end
        EXEC: begin
          work_reg <= step_next;
          cnt_reg  <= cnt_reg - 1'b1;
          if (cnt_reg == SHW'(1)) begin
            res_reg   <= step_next;
            carry_reg <= step_out;
            ovf_reg   <= 1'b0;
            cero_reg  <= (step_next == '0);
            neg_reg   <= step_next[WIDTH-1];
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (is_arith(op_reg)) begin
              c_reg <= carry_reg;
            end
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign Resultado = res_reg;
  assign carry_out = carry_reg;
  assign overflow  = ovf_reg;
  assign cero      = cero_reg;
  assign negativo  = neg_reg;

endmodule
